// File: rtl/regfile_pkg.sv
// Shared encodings for the bit-serial register file: shift modes and sequencer states.
package regfile_pkg;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_SRA  = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_operand_select.sv
// Picks one bit of a snapshotted operand for the current serial step, applying
// SLL/SRL/SRA as index arithmetic instead of a barrel shifter.
module serial_operand_select
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int BW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] op,
    input  shift_mode_e      mode,
    input  logic [BW-1:0]    shamt,
    input  logic [BW-1:0]    bit_index,
    output logic             bit_out
);

    localparam logic [BW:0] W_EXT = (BW + 1)'(WIDTH);

    // One extra bit so i+s and i-s can be range-checked without wrapping.
    logic [BW:0] idx_ext;
    logic [BW:0] sh_ext;
    logic [BW:0] sum;
    logic [BW:0] diff;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bit_out = 1'b0;
        idx_ext = {1'b0, bit_index};
        sh_ext  = {1'b0, shamt};
        sum     = idx_ext + sh_ext;
        diff    = idx_ext - sh_ext;
        case (mode)
            SH_PASS: bit_out = op[bit_index];
            SH_SLL:  bit_out = (idx_ext >= sh_ext) ? op[diff[BW-1:0]] : 1'b0;
            SH_SRL:  bit_out = (sum < W_EXT) ? op[sum[BW-1:0]] : 1'b0;
            SH_SRA:  bit_out = (sum < W_EXT) ? op[sum[BW-1:0]] : op[WIDTH-1];
            default: bit_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_serial_sequenced.sv
// Bit-serial register file: snapshots two operands on start, streams them LSB-first
// to the serial ALU, assembles the returned bits and commits them to rd in one write.
module regfile_serial_sequenced
    import regfile_pkg::*;
#(
    parameter  int REG_WIDTH = 8,
    parameter  int REG_COUNT = 8,
    localparam int AW        = $clog2(REG_COUNT),
    localparam int BW        = $clog2(REG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    input  logic [AW-1:0]        rd_addr,
    input  logic [1:0]           shift_mode,
    input  logic [BW-1:0]        shamt,
    input  logic                 wb_en,
    input  logic                 rd_bit_in,
    input  logic                 par_we,
    input  logic [AW-1:0]        par_addr,
    input  logic [REG_WIDTH-1:0] par_wdata,
    output logic                 busy,
    output logic                 done,
    output logic [BW-1:0]        bit_index,
    output logic                 rs1_bit,
    output logic                 rs2_bit,
    output logic [REG_WIDTH-1:0] rs1_parallel
);

    localparam logic [BW-1:0] LAST_BIT = BW'(REG_WIDTH - 1);

    state_e               state;
    logic [REG_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_WIDTH-1:0] op1;
    logic [REG_WIDTH-1:0] op2;
    logic [REG_WIDTH-1:0] result;
    logic [AW-1:0]        rd_q;
    shift_mode_e          mode_q;
    logic [BW-1:0]        shamt_q;
    logic                 wb_q;
    logic                 rs1_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_index <= '0;
            op1       <= '0;
            op2       <= '0;
            result    <= '0;
            rd_q      <= '0;
            mode_q    <= SH_PASS;
            shamt_q   <= '0;
            wb_q      <= 1'b0;
            // NOTE: the array is cleared on reset because software relies on all-zero registers.
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking writes, so the start snapshot below sees pre-write array values.
            if (par_we && par_addr != '0) begin
                regs[par_addr] <= par_wdata;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op1       <= (rs1_addr == '0) ? '0 : regs[rs1_addr];
                        op2       <= (rs2_addr == '0) ? '0 : regs[rs2_addr];
                        rd_q      <= rd_addr;
                        mode_q    <= shift_mode_e'(shift_mode);
                        shamt_q   <= shamt;
                        wb_q      <= wb_en;
                        bit_index <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    result[bit_index] <= rd_bit_in;
                    if (bit_index == LAST_BIT) begin
                        bit_index <= '0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        bit_index <= bit_index + BW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    // Placed after the parallel write so the serial commit wins on the same rd.
                    if (wb_q && rd_q != '0) begin
                        regs[rd_q] <= result;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    serial_operand_select #(.WIDTH(REG_WIDTH)) u_rs1_sel (
        .op        (op1),
        .mode      (mode_q),
        .shamt     (shamt_q),
        .bit_index (bit_index),
        .bit_out   (rs1_sel)
    );

    assign rs1_bit      = (state == ST_SHIFT) && rs1_sel;
    assign rs2_bit      = (state == ST_SHIFT) && op2[bit_index];
    assign rs1_parallel = (rs1_addr == '0) ? '0 : regs[rs1_addr];

endmodule
